// File: rtl/uart_rx_if.sv
// Signal bundle between the 8N1 serial receiver and the I/O-mapped UART device logic.
// master drives the line and the pop/clear strobes; slave is the receiver.
interface uart_rx_if;
  logic       rx;
  logic       rd;
  logic       clr_err;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx, rd, clr_err,
    input  data, valid, busy, frame_err, overrun
  );

  modport slave (
    input  rx, rd, clr_err,
    output data, valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, centre-sampled 3-way majority vote, byte buffer.
// Define UART_RX_FIFO_EN for a 4-deep FIFO; otherwise a single holding register is used.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 10_000_000,
  parameter int unsigned BAUD     = 1_000_000
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned H            = CLKS_PER_BIT / 2;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntS0   = CntW'(H - 1);
  localparam logic [CntW-1:0] CntS1   = CntW'(H);
  localparam logic [CntW-1:0] CntDec  = CntW'(H + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_chk_cpb
    $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
  end
  if (CLK_FREQ % BAUD != 0) begin : g_chk_div
    $error("uart_rx: CLK_FREQ must be an integer multiple of BAUD");
  end

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic            rx_m_q, rx_s_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bitn_q, bitn_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      smp_q, smp_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            maj;
  logic            push;
  logic            frame_set;
  logic            pop;
  logic            ovr_set;

  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

  // The first two votes are held; the third is the live rx_s at the decision count.
  always_comb begin
    smp_d = smp_q;
    if (state_q != StIdle && state_q != StBreak) begin
      if (cnt_q == CntS0) smp_d[0] = rx_s_q;
      if (cnt_q == CntS1) smp_d[1] = rx_s_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitn_d    = bitn_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == CntDec && maj) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StData;
          cnt_d   = '0;
          bitn_d  = '0;
        end
      end
      StData: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == CntDec) shift_d = {maj, shift_q[7:1]};
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (bitn_q == 3'd7) state_d = StStop;
          else                bitn_d  = bitn_q + 3'd1;
        end
      end
      StStop: begin
        cnt_d = cnt_q + CntOne;
        // Leave mid-stop-bit so a start edge right after the centre is not missed.
        if (cnt_q == CntDec) begin
          cnt_d = '0;
          if (maj) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_set = 1'b1;
            state_d   = StBreak;
          end
        end
      end
      StBreak: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shift_q     <= '0;
      smp_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_m_q      <= bus.rx;
      rx_s_q      <= rx_m_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      shift_q     <= shift_d;
      smp_q       <= smp_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0] count_q, count_d;
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic       full;
  logic       do_push;

  assign full    = (count_q == 3'd4);
  assign pop     = bus.rd && (count_q != 3'd0);
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = shift_q;
      wptr_d        = wptr_q + 2'd1;
    end
    if (pop) rptr_d = rptr_q + 2'd1;
    if (do_push && !pop)      count_d = count_q + 3'd1;
    else if (!do_push && pop) count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign bus.data  = mem_q[rptr_q];
  assign bus.valid = (count_q != 3'd0);
`else
  logic [7:0] hold_q, hold_d;
  logic       hv_q, hv_d;
  logic       do_push;

  assign pop     = bus.rd && hv_q;
  assign do_push = push && (!hv_q || pop);
  assign ovr_set = push && hv_q && !pop;

  always_comb begin
    hold_d = do_push ? shift_q : hold_q;
    hv_d   = do_push | (hv_q & ~pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      hv_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hv_q   <= hv_d;
    end
  end

  assign bus.data  = hold_q;
  assign bus.valid = hv_q;
`endif

  // Set beats clear when both land in the same cycle.
  always_comb begin
    frame_err_d = frame_set | (frame_err_q & ~bus.clr_err);
    overrun_d   = ovr_set | (overrun_q & ~bus.clr_err);
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: frame-level line driver, expected-byte queue, pop monitor.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 10_000_000;
  localparam int unsigned BAUD      = 1_000_000;
  localparam int unsigned CPB       = CLK_FREQ / BAUD;
  localparam int unsigned HC        = CPB / 2;
  localparam int unsigned PUSH_EDGE = 9 * CPB + HC + 4;
`ifdef UART_RX_FIFO_EN
  localparam int unsigned D = 4;
`else
  localparam int unsigned D = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  logic [7:0]  exp_q[$];
  bit          auto_drain = 1'b0;
  bit          rd_force   = 1'b0;
  int unsigned model_cnt  = 0;
  bit          exp_ovr    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reader side: pop whenever draining is enabled, or on a forced one-cycle strobe.
  always @(posedge clk) begin
    #2;
    bus.rd = (auto_drain && bus.valid) || rd_force;
  end

  // Every pop presented to the DUT is scored against the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && bus.rd && bus.valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h, expected none", bus.data);
      end else begin
        check("rx_byte", {24'h0, bus.data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic drive_frame(input logic [7:0] b, input int unsigned stop_cycles,
                             input logic stop_val);
    bus.rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      idle(CPB);
    end
    bus.rx = stop_val;
    idle(stop_cycles);
    bus.rx = 1'b1;
  endtask

  // Reference model of the buffer at frame granularity.
  task automatic send_good(input logic [7:0] b);
    if (auto_drain) begin
      exp_q.push_back(b);
    end else if (model_cnt < D) begin
      exp_q.push_back(b);
      model_cnt++;
    end else begin
      exp_ovr = 1'b1;
    end
    drive_frame(b, CPB, 1'b1);
  endtask

  task automatic wait_empty(input string name);
    int unsigned t = 0;
    while ((exp_q.size() != 0 || bus.valid) && t < 40 * CPB) begin
      idle(1);
      t++;
    end
    check({"drain_", name}, exp_q.size(), 0);
    model_cnt = 0;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    idle(1);
    bus.clr_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_data"}, bus.data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    bus.rx      = 1'b1;
    bus.clr_err = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(5);

    // Single byte with latency and busy timing.
    auto_drain = 1'b0;
    model_cnt  = 0;
    @(posedge clk);
    #1;
    fork
      send_good(8'hA5);
      begin
        repeat (2) @(posedge clk);
        #1;
        check("busy_edge1", bus.busy, 0);
        @(posedge clk);
        #1;
        check("busy_edge2", bus.busy, 1);
        repeat (PUSH_EDGE - 3) @(posedge clk);
        #1;
        check("valid_before_push", bus.valid, 0);
        check("busy_before_push", bus.busy, 1);
        @(posedge clk);
        #1;
        check("valid_at_push", bus.valid, 1);
        check("data_at_push", bus.data, 8'hA5);
        check("busy_after_stop", bus.busy, 0);
        check("frame_err_single", bus.frame_err, 0);
      end
    join
    auto_drain = 1'b1;
    wait_empty("single");
    check("valid_after_rd", bus.valid, 0);

    // Glitch rejection.
    bus.rx = 1'b0;
    idle(3);
    bus.rx = 1'b1;
    idle(2 * CPB);
    check("glitch_busy", bus.busy, 0);
    check("glitch_valid", bus.valid, 0);
    send_good(8'h3C);
    wait_empty("glitch");

    // Framing error with a long low stop, then recovery.
    drive_frame(8'h55, 2 * CPB, 1'b0);
    idle(4);
    check("frame_err_set", bus.frame_err, 1);
    check("frame_err_no_push", bus.valid, 0);
    idle(CPB);
    send_good(8'h12);
    wait_empty("after_break");
    check("frame_err_sticky", bus.frame_err, 1);
    pulse_clr();
    check("frame_err_cleared", bus.frame_err, 0);

    // Random back-to-back and spaced frames, drained continuously.
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      send_good(b);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2 * CPB));
    end
    wait_empty("random");
    check("random_frame_err", bus.frame_err, 0);
    check("random_overrun", bus.overrun, 0);

    // Overrun: five frames with no reads; clear lands on the last drop edge.
    auto_drain = 1'b0;
    model_cnt  = 0;
    exp_ovr    = 1'b0;
    for (int i = 1; i <= 4; i++) send_good(8'(i));
    fork
      send_good(8'h05);
      begin
        repeat (PUSH_EDGE) @(posedge clk);
        #1;
        bus.clr_err = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_err = 1'b0;
      end
    join
    idle(2 * CPB);
    check("overrun_flag", bus.overrun, 32'(exp_ovr));
    check("overrun_valid", bus.valid, 1);
    auto_drain = 1'b1;
    wait_empty("overrun");
    pulse_clr();
    check("overrun_cleared", bus.overrun, 0);

    // Push and pop on the same edge at full.
    auto_drain = 1'b0;
    model_cnt  = 0;
    for (int i = 0; i < int'(D); i++) send_good(8'($urandom_range(0, 255)));
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    fork
      drive_frame(b, CPB, 1'b1);
      begin
        repeat (PUSH_EDGE) @(posedge clk);
        #1;
        rd_force = 1'b1;
        @(posedge clk);
        #1;
        rd_force = 1'b0;
      end
    join
    idle(CPB);
    check("pushpop_overrun", bus.overrun, 0);
    check("pushpop_valid", bus.valid, 1);
    auto_drain = 1'b1;
    wait_empty("pushpop");

    // Reset during data bit 4, held through the end of that frame.
    fork
      drive_frame(8'hF0, CPB, 1'b1);
      begin
        repeat (2 + 5 * CPB + HC) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midframe_reset");
      end
    join
    idle(2);
    rst_n = 1'b1;
    idle(CPB);
    send_good(8'hC3);
    wait_empty("after_reset");
    check("final_frame_err", bus.frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
